// File: rtl/add_display_sequencer_pkg.sv
// rtl/add_display_sequencer_pkg.sv - shared state encoding and seven-segment font
package add_display_sequencer_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low gfedcba patterns, entry 0 at the right.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/add_display_sequencer_seven_seg_decoder.sv
// rtl/add_display_sequencer_seven_seg_decoder.sv - 4-bit hex to active-low abcdefg segments
module seven_seg_decoder
    import add_display_sequencer_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = SEG_FONT[value];

endmodule

// File: rtl/add_display_sequencer.sv
// rtl/add_display_sequencer.sv - button-driven enter A, enter B, add and display sequencer
module add_display_sequencer
    import add_display_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_W = 16,
    parameter int BLINK_W    = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] sw,
    output logic [7:0] hex2,
    output logic [7:0] hex1,
    output logic [7:0] hex0,
    output logic [2:0] led
);

    logic                  key_meta;
    logic                  key_sync;
    logic                  stable;
    logic                  stable_d;
    logic [DEBOUNCE_W-1:0] db_cnt;
    logic                  press;

    state_t                state;
    logic [3:0]            reg_a;
    logic [3:0]            reg_b;
    logic [4:0]            reg_sum;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blank_phase;

    logic [3:0]            dig2_val;
    logic [3:0]            dig1_val;
    logic [6:0]            seg2;
    logic [6:0]            seg1;
    logic [6:0]            seg0;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            stable_d <= stable;
            if (key_sync == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == '1) begin
                stable <= key_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Only the falling edge of the debounced level counts as a press.
    assign press = stable_d & ~stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ENTER_A;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_sum   <= '0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            case (state)
                ENTER_A: begin
                    if (press) begin
                        reg_a     <= sw;
                        state     <= ENTER_B;
                        blink_cnt <= '0;
                    end
                end
                ENTER_B: begin
                    if (press) begin
                        reg_b     <= sw;
                        state     <= CALC;
                        blink_cnt <= '0;
                    end
                end
                CALC: begin
                    reg_sum   <= {1'b0, reg_a} + {1'b0, reg_b};
                    state     <= SHOW;
                    blink_cnt <= '0;
                end
                SHOW: begin
                    if (press) begin
                        state     <= ENTER_A;
                        blink_cnt <= '0;
                    end
                end
                default: begin
                    state     <= ENTER_A;
                    blink_cnt <= '0;
                end
            endcase
        end
    end

    assign blank_phase = blink_cnt[BLINK_W-1];
    assign dig2_val    = (state == ENTER_A) ? sw : reg_a;
    assign dig1_val    = (state == ENTER_B) ? sw : reg_b;

    seven_seg_decoder u_dec2 (.value(dig2_val),     .seg(seg2));
    seven_seg_decoder u_dec1 (.value(dig1_val),     .seg(seg1));
    seven_seg_decoder u_dec0 (.value(reg_sum[3:0]), .seg(seg0));

    always_comb begin
        hex2 = SEG_BLANK;
        hex1 = SEG_BLANK;
        hex0 = SEG_BLANK;
        led  = 3'b001;
        case (state)
            ENTER_A: begin
                hex2 = blank_phase ? SEG_BLANK : {1'b1, seg2};
                led  = 3'b001;
            end
            ENTER_B: begin
                hex2 = {1'b1, seg2};
                hex1 = blank_phase ? SEG_BLANK : {1'b1, seg1};
                led  = 3'b010;
            end
            CALC, SHOW: begin
                hex2 = {1'b1, seg2};
                hex1 = {1'b1, seg1};
                hex0 = {~reg_sum[4], seg0};
                led  = 3'b100;
            end
            default: begin
                led = 3'b001;
            end
        endcase
    end

endmodule

// File: tb/tb_add_display_sequencer.sv
// tb/tb_add_display_sequencer.sv - self-checking bench for add_display_sequencer
module tb_add_display_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic [3:0] sw = 4'd0;
    logic [7:0] hex2;
    logic [7:0] hex1;
    logic [7:0] hex0;
    logic [2:0] led;

    int checks = 0;
    int errors = 0;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    add_display_sequencer #(.DEBOUNCE_W(2), .BLINK_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .sw    (sw),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press();
        key_n = 1'b0;
        tick(12);
        key_n = 1'b1;
        tick(12);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Reference: enter a then b, expect sum digits and carry dot in SHOW.
    task automatic run_sum(input logic [3:0] a, input logic [3:0] b, input string tag);
        int sum;
        sum = int'(a) + int'(b);
        sw = a;
        press();
        chk({tag, "_led_b"}, {5'd0, led}, 8'h02);
        chk({tag, "_hex2_b"}, hex2, font[a]);
        sw = b;
        press();
        chk({tag, "_led_s"}, {5'd0, led}, 8'h04);
        chk({tag, "_hex2"}, hex2, font[a]);
        chk({tag, "_hex1"}, hex1, font[b]);
        chk({tag, "_hex0"}, hex0, {(sum < 16), font[sum % 16][6:0]});
    endtask

    initial begin
        int found;
        sw = 4'd5;
        do_reset();
        chk("rst_hex2", hex2, 8'h92);
        chk("rst_hex1", hex1, 8'hFF);
        chk("rst_hex0", hex0, 8'hFF);
        chk("rst_led", {5'd0, led}, 8'h01);

        run_sum(4'd9, 4'd8, "s98");
        chk("s98_raw", hex0, 8'h79);
        press();
        run_sum(4'd3, 4'd4, "s34");
        chk("s34_raw", hex0, 8'hF8);
        press();
        chk("show_exit_led", {5'd0, led}, 8'h01);
        chk("show_exit_hex0", hex0, 8'hFF);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_sum(ra, rb, $sformatf("rnd%0d", i));
            press();
            chk($sformatf("rnd%0d_back", i), {5'd0, led}, 8'h01);
        end

        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(20);
        chk("glitch_led", {5'd0, led}, 8'h01);
        key_n = 1'b0;
        tick(100);
        chk("hold_led", {5'd0, led}, 8'h02);
        key_n = 1'b1;
        tick(20);
        chk("release_led", {5'd0, led}, 8'h02);
        sw = 4'd1;
        press();
        press();
        chk("hold_back_led", {5'd0, led}, 8'h01);

        sw = 4'd0;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("blink_a%0d", k), hex2, ((k / 8) % 2 == 0) ? 8'hC0 : 8'hFF);
            tick(1);
        end

        sw = 4'd6;
        key_n = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            tick(1);
            if (led == 3'b010) found = 1;
        end
        chk("blink_b_seen", found[7:0], 8'h01);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("blink_b%0d", j), hex1, (j < 8) ? 8'h82 : 8'hFF);
            tick(1);
        end
        key_n = 1'b1;
        tick(12);
        sw = 4'd2;
        press();
        chk("pre_rst_led", {5'd0, led}, 8'h04);

        reset = 1'b1;
        tick(1);
        chk("midrst_led", {5'd0, led}, 8'h01);
        chk("midrst_hex0", hex0, 8'hFF);
        chk("midrst_hex1", hex1, 8'hFF);
        reset = 1'b0;
        tick(1);
        run_sum(4'd0, 4'd0, "s00");
        chk("s00_raw", hex0, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_display_sequencer.md
Name: add_display_sequencer

Overview:
- Sequences a 4-bit add-and-display datapath on the DE10-Lite.
- The user enters operand A, then operand B, on sw[3:0], confirming each with a push-button.
- The block then registers the sum and shows A, B and the sum on three seven-segment digits, with the carry shown as a lit dot.
- It sits between the board switches/button and the hex displays, and owns button conditioning, the state machine, and the blink of the digit being entered.

Parameters:
- DEBOUNCE_W, 16: debounce counter width. A level change is accepted only after it is stable for 2^DEBOUNCE_W cycles.
- BLINK_W, 24: free-running blink counter width. The blink half-period is 2^(BLINK_W-1) cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key_n  input  1  raw push-button, active-low, asynchronous to clk
- sw  input  4  operand value being entered
- hex2  output  8  operand A digit, {dot, g..a}, active-low
- hex1  output  8  operand B digit, same format
- hex0  output  8  sum digit; dot = ~carry
- led  output  3  one-hot state indicator

Behaviour:
- One clock, clk. Reset is synchronous and active-high; reset has priority over every other event in the same cycle.
- Button conditioning:
  - key_n passes through a 2-FF synchronizer; both FFs reset to 1.
  - Debounce: stable (reset 1) and counter (reset 0). counter clears when sync == stable and increments when they differ. When counter is all-ones and sync != stable, stable <= sync on the next edge.
  - press is a one-cycle pulse on the stable 1->0 transition. Release produces no pulse. A held button gives exactly one pulse.
- Blink:
  - blink_cnt is free-running, resets to 0, and also clears to 0 on every state transition.
  - blank_phase = blink_cnt[BLINK_W-1].
- States (reset -> ENTER_A):
  - ENTER_A:
    - hex2 = decode(sw), or 8'hFF when blank_phase.
    - hex1 = hex0 = 8'hFF.
    - On press: reg_a <= sw, go to ENTER_B.
  - ENTER_B:
    - hex2 = decode(reg_a), steady.
    - hex1 = decode(sw), blinking.
    - hex0 = 8'hFF.
    - On press: reg_b <= sw, go to CALC.
  - CALC:
    - Exactly one cycle: reg_sum[4:0] <= reg_a + reg_b, zero-extended to 5 bits. Go to SHOW.
    - Any press in this cycle is dropped.
    - Outputs as in SHOW, using the old reg_sum.
  - SHOW:
    - hex2 = decode(reg_a), hex1 = decode(reg_b), hex0 = {~reg_sum[4], decode(reg_sum[3:0])}.
    - On press: go to ENTER_A. Registers hold until overwritten.
- Outputs:
  - Dot bit 7 = 1 (off) on hex1 and hex2 always, and on hex0 except in SHOW/CALC with carry.
  - Digit patterns are the standard active-low 0-F hex font.
- Registers: reg_a, reg_b and reg_sum reset to 0.
- led: 3'b001 in ENTER_A, 3'b010 in ENTER_B, 3'b100 in CALC/SHOW.
- Outputs are combinational from state, registers, sw and blink_cnt.
- Values right after reset: hex1 = hex0 = 8'hFF, hex2 = {1, decode(sw)} (visible), led = 3'b001.
- Latency: about 2 + 2^DEBOUNCE_W + 1 cycles from a stable key_n fall to the state change. Glitches shorter than 2^DEBOUNCE_W cycles are ignored.
- Reset mid-operation, including mid-debounce: returns to ENTER_A with all counters cleared. A button still held after reset is seen as a new press only after a full debounce.

Decomposition:
- Shared package: state encoding (ENTER_A, ENTER_B, CALC, SHOW), SEG_BLANK = 8'hFF, and the 16-entry hex segment font.
- One sub-module, seven_seg_decoder: 4-bit in, 7-bit abcdefg active-low out, instantiated three times.
- Debouncer and state machine stay inline.

Test Plan (DEBOUNCE_W=2, BLINK_W=4):
- Reset with sw=5 -> hex2=8'h92, hex1=hex0=8'hFF, led=3'b001.
- sw=9, press; sw=8, press; wait 2 cycles -> led=3'b100, hex2=8'h90, hex1=8'h80, hex0=8'h79 (sum 0x11, dot lit).
- 3+4 sequence -> hex0=8'hF8 (7, dot off). Press in SHOW -> ENTER_A, hex0=8'hFF.
- key_n low for 3 cycles -> no state change. Low for 100 cycles -> exactly one advance. Release -> no advance.
- In ENTER_A, sw=0 -> hex2 shows 8'hC0 for 8 cycles, then 8'hFF for 8 cycles, and repeats. A state change restarts the visible phase.
- Assert reset during SHOW -> next cycle led=3'b001, hex0=hex1=8'hFF. A following 0+0 sequence -> hex0=8'hC0.
